// File: rtl/answer_checker_if.sv
// Bus between the question generator/keypad (master) and the answer checker (slave).
interface answer_checker_if;
  logic        start;
  logic [11:0] exp;
  logic [1:0]  line;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_enter;
  logic        key_clear;
  logic        busy;
  logic [6:0]  expected;
  logic [6:0]  answer;
  logic [1:0]  lane;
  logic        correct;
  logic        wrong;
  logic        err;
  logic        done;
  logic [7:0]  score;

  modport master (
    output start, exp, line, key, key_valid, key_enter, key_clear,
    input  busy, expected, answer, lane, correct, wrong, err, done, score
  );

  modport slave (
    input  start, exp, line, key, key_valid, key_enter, key_clear,
    output busy, expected, answer, lane, correct, wrong, err, done, score
  );
endinterface

// File: rtl/answer_checker.sv
// Evaluates a latched {num1,op,num2} expression, collects a keypad answer,
// judges it and keeps a saturating score of correct answers.
module answer_checker #(
  parameter int unsigned TIMEOUT  = 1000,
  parameter int unsigned SHOW_CYC = 50
) (
  input logic             clk,
  input logic             rst,
  answer_checker_if.slave bus
);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned SW = $clog2(SHOW_CYC + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CALC  = 3'd1;
  localparam logic [2:0] S_INPUT = 3'd2;
  localparam logic [2:0] S_JUDGE = 3'd3;
  localparam logic [2:0] S_SHOW  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [3:0]    n1_q, n1_d, n2_q, n2_d, op_q, op_d;
  logic [3:0]    quo_q, quo_d, rem_q, rem_d;
  logic [1:0]    step_q, step_d, ndig_q, ndig_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [SW-1:0] shw_q, shw_d;
  logic          busy_q, busy_d, correct_q, correct_d, wrong_q, wrong_d;
  logic          err_q, err_d, done_q, done_d;
  logic [6:0]    expected_q, expected_d, answer_q, answer_d;
  logic [1:0]    lane_q, lane_d;
  logic [7:0]    score_q, score_d;
  logic [4:0]    rem_t;
  logic [3:0]    rem_n, quo_n;
  logic          legal;

  // Operands 1..9 and op A..D are the only legal expressions.
  assign legal = (bus.exp[11:8] != 4'd0) && (bus.exp[11:8] <= 4'd9) &&
                 (bus.exp[3:0]  != 4'd0) && (bus.exp[3:0]  <= 4'd9) &&
                 (bus.exp[7:4]  >= 4'hA) && (bus.exp[7:4]  <= 4'hD);

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d    = state_q;
    n1_d       = n1_q;
    n2_d       = n2_q;
    op_d       = op_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    step_d     = step_q;
    ndig_d     = ndig_q;
    tmo_d      = tmo_q;
    shw_d      = shw_q;
    correct_d  = correct_q;
    wrong_d    = wrong_q;
    err_d      = err_q;
    done_d     = 1'b0;
    expected_d = expected_q;
    answer_d   = answer_q;
    lane_d     = lane_q;
    score_d    = score_q;

    // One restoring-division step: shift in the next dividend bit, try subtract.
    rem_t = {rem_q, quo_q[3]};
    if (rem_t >= 5'(n2_q)) begin
      rem_n = 4'(rem_t - 5'(n2_q));
      quo_n = {quo_q[2:0], 1'b1};
    end else begin
      rem_n = rem_t[3:0];
      quo_n = {quo_q[2:0], 1'b0};
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          n1_d       = bus.exp[11:8];
          op_d       = bus.exp[7:4];
          n2_d       = bus.exp[3:0];
          lane_d     = bus.line;
          quo_d      = bus.exp[11:8];
          rem_d      = 4'd0;
          step_d     = 2'd0;
          ndig_d     = 2'd0;
          answer_d   = 7'd0;
          expected_d = 7'd0;
          if (legal) begin
            state_d = S_CALC;
          end else begin
            err_d   = 1'b1;
            shw_d   = '0;
            state_d = S_SHOW;
          end
        end
      end
      S_CALC: begin
        tmo_d   = '0;
        state_d = S_INPUT;
        case (op_q)
          4'hA: expected_d = 7'(n1_q) + 7'(n2_q);
          4'hB: expected_d = (n1_q >= n2_q) ? 7'(n1_q - n2_q) : 7'(n2_q - n1_q);
          4'hC: expected_d = 7'(n1_q) * 7'(n2_q);
          default: begin
            quo_d  = quo_n;
            rem_d  = rem_n;
            step_d = step_q + 2'd1;
            if (step_q == 2'd3) begin
              expected_d = 7'(quo_n);
            end else begin
              state_d = S_CALC;
            end
          end
        endcase
      end
      S_INPUT: begin
        tmo_d = tmo_q + TW'(1);
        if (tmo_q == TW'(TIMEOUT - 1)) begin
          wrong_d = 1'b1;
          shw_d   = '0;
          state_d = S_SHOW;
        end else if (bus.key_clear) begin
          answer_d = 7'd0;
          ndig_d   = 2'd0;
        end else if (bus.key_enter) begin
          if (ndig_q != 2'd0) state_d = S_JUDGE;
        end else if (bus.key_valid && (bus.key <= 4'd9) && (ndig_q < 2'd2)) begin
          answer_d = 7'(answer_q * 7'd10) + 7'(bus.key);
          ndig_d   = ndig_q + 2'd1;
        end
      end
      S_JUDGE: begin
        if (answer_q == expected_q) begin
          correct_d = 1'b1;
          if (score_q != 8'hFF) score_d = score_q + 8'd1;
        end else begin
          wrong_d = 1'b1;
        end
        shw_d   = '0;
        state_d = S_SHOW;
      end
      S_SHOW: begin
        shw_d = shw_q + SW'(1);
        if (shw_q == SW'(SHOW_CYC - 1)) begin
          correct_d = 1'b0;
          wrong_d   = 1'b0;
          err_d     = 1'b0;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n1_q       <= 4'd0;
      n2_q       <= 4'd0;
      op_q       <= 4'd0;
      quo_q      <= 4'd0;
      rem_q      <= 4'd0;
      step_q     <= 2'd0;
      ndig_q     <= 2'd0;
      tmo_q      <= '0;
      shw_q      <= '0;
      busy_q     <= 1'b0;
      correct_q  <= 1'b0;
      wrong_q    <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      expected_q <= 7'd0;
      answer_q   <= 7'd0;
      lane_q     <= 2'd0;
      score_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      n1_q       <= n1_d;
      n2_q       <= n2_d;
      op_q       <= op_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      step_q     <= step_d;
      ndig_q     <= ndig_d;
      tmo_q      <= tmo_d;
      shw_q      <= shw_d;
      busy_q     <= busy_d;
      correct_q  <= correct_d;
      wrong_q    <= wrong_d;
      err_q      <= err_d;
      done_q     <= done_d;
      expected_q <= expected_d;
      answer_q   <= answer_d;
      lane_q     <= lane_d;
      score_q    <= score_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.expected = expected_q;
  assign bus.answer   = answer_q;
  assign bus.lane     = lane_q;
  assign bus.correct  = correct_q;
  assign bus.wrong    = wrong_q;
  assign bus.err      = err_q;
  assign bus.done     = done_q;
  assign bus.score    = score_q;
endmodule
